// File: rtl/button_conditioner.sv
// button_conditioner
//
// Purpose: conditions raw board push-buttons and switches for control FSMs.
// Each channel is independent and runs:
//   - a synchroniser chain,
//   - a counter-based debouncer,
//   - edge strobes,
//   - a fixed-length event pulse.
// A held or bouncing button therefore yields one clean event.
//
// Ports:
//   clk        system clock, all logic on posedge
//   rst        synchronous active-high reset; clears every flop and aborts
//              any debounce or pulse in progress
//   btn_in     [CHANNELS] raw asynchronous button inputs
//   btn_level  [CHANNELS] debounced level
//   btn_pulse  [CHANNELS] PULSE_LEN-cycle event pulse; a new event retriggers
//              the pulse, so it is extended rather than doubled
//   btn_rise   [CHANNELS] 1-cycle strobe when btn_level rises
//   btn_fall   [CHANNELS] 1-cycle strobe when btn_level falls
//
// EDGE_MODE selects which edge is an event:
//   0 = rising, 1 = falling, 2 = both.
//
// Optional feature (macro BUTTON_CONDITIONER_AUTOREPEAT_EN):
//   While a channel is held high, btn_pulse re-fires after REPEAT_DELAY
//   cycles and then every REPEAT_PERIOD cycles. Repeats never touch
//   btn_rise or btn_fall.
//   Without the macro there is no repeat logic; the REPEAT_* parameters are
//   only range-checked.
module button_conditioner #(
  parameter int CHANNELS        = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int PULSE_LEN       = 1,
  parameter int EDGE_MODE       = 0,
  parameter int REPEAT_DELAY    = 500000,
  parameter int REPEAT_PERIOD   = 100000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] btn_in,
  output logic [CHANNELS-1:0] btn_level,
  output logic [CHANNELS-1:0] btn_pulse,
  output logic [CHANNELS-1:0] btn_rise,
  output logic [CHANNELS-1:0] btn_fall
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PLS_W = $clog2(PULSE_LEN + 1);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEB_ONE  = CNT_W'(1);
  localparam logic [PLS_W-1:0] PLS_LOAD = PLS_W'(PULSE_LEN);
  localparam logic [PLS_W-1:0] PLS_ONE  = PLS_W'(1);

`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX + 1);

  localparam logic [REP_W-1:0] REP_DLY_LAST = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] REP_PER_LAST = REP_W'(REPEAT_PERIOD - 1);
  localparam logic [REP_W-1:0] REP_ONE      = REP_W'(1);
`endif

  if (CHANNELS < 1) begin : g_bad_channels
    $error("button_conditioner: CHANNELS must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("button_conditioner: SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("button_conditioner: DEBOUNCE_CYCLES must be >= 1");
  end
  if (PULSE_LEN < 1) begin : g_bad_pulse
    $error("button_conditioner: PULSE_LEN must be >= 1");
  end
  if (EDGE_MODE < 0 || EDGE_MODE > 2) begin : g_bad_mode
    $error("button_conditioner: EDGE_MODE must be 0, 1 or 2");
  end
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
    $error("button_conditioner: REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end

  // Map the debounced edge strobes onto the configured event.
  function automatic logic edge_event(input logic rise, input logic fall);
    case (EDGE_MODE)
      0:       return rise;
      1:       return fall;
      default: return rise | fall;
    endcase
  endfunction

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_p0;
    logic                   s_p0;
    logic [CNT_W-1:0]       deb_cnt_p1;
    logic                   level_p1;
    logic                   rise_p1;
    logic                   fall_p1;
    logic [PLS_W-1:0]       pulse_cnt_p1;
    logic                   accept;
    logic                   rise_nxt;
    logic                   fall_nxt;
    logic                   rep_fire;
    logic                   fire;

    // Stage 0: synchroniser chain; the last flop is the stable sample.
    always_ff @(posedge clk) begin
      if (rst) begin
        sync_p0 <= '0;
      end else begin
        sync_p0 <= {sync_p0[SYNC_STAGES-2:0], btn_in[ch]};
      end
    end

    assign s_p0 = sync_p0[SYNC_STAGES-1];

    // The new level is accepted on the cycle its count completes.
    // Rise/fall are registered alongside it, so all three change together.
    assign accept   = (s_p0 != level_p1) && (deb_cnt_p1 == DEB_LAST);
    assign rise_nxt = accept & s_p0;
    assign fall_nxt = accept & ~s_p0;

    // Stage 1: debounce counter, debounced level and edge strobes.
    always_ff @(posedge clk) begin
      if (rst) begin
        deb_cnt_p1 <= '0;
        level_p1   <= 1'b0;
        rise_p1    <= 1'b0;
        fall_p1    <= 1'b0;
      end else begin
        rise_p1 <= rise_nxt;
        fall_p1 <= fall_nxt;
        if (s_p0 == level_p1) begin
          // Any bounce back to the current level restarts the count.
          deb_cnt_p1 <= '0;
        end else if (deb_cnt_p1 == DEB_LAST) begin
          level_p1   <= s_p0;
          deb_cnt_p1 <= '0;
        end else begin
          deb_cnt_p1 <= deb_cnt_p1 + DEB_ONE;
        end
      end
    end

`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
    logic [REP_W-1:0] rep_cnt_p1;
    logic             rep_periodic_p1;

    // rep_cnt equals the number of cycles since the last pulse (or since the
    // rise). The first wait is REPEAT_DELAY; after that it is REPEAT_PERIOD.
    assign rep_fire = level_p1 && !fall_nxt &&
                      (rep_periodic_p1 ? (rep_cnt_p1 == REP_PER_LAST)
                                       : (rep_cnt_p1 == REP_DLY_LAST));

    // Stage 1: auto-repeat timer, cleared whenever the channel is released.
    always_ff @(posedge clk) begin
      if (rst || !level_p1 || fall_nxt) begin
        rep_cnt_p1      <= '0;
        rep_periodic_p1 <= 1'b0;
      end else if (rep_fire) begin
        rep_cnt_p1      <= '0;
        rep_periodic_p1 <= 1'b1;
      end else begin
        rep_cnt_p1 <= rep_cnt_p1 + REP_ONE;
      end
    end
`else
    assign rep_fire = 1'b0;
`endif

    assign fire = edge_event(rise_nxt, fall_nxt) | rep_fire;

    // Stage 1: pulse down-counter, loaded in the same cycle as the level
    // change. Reloading on a new event extends the pulse.
    always_ff @(posedge clk) begin
      if (rst) begin
        pulse_cnt_p1 <= '0;
      end else if (fire) begin
        pulse_cnt_p1 <= PLS_LOAD;
      end else if (pulse_cnt_p1 != '0) begin
        pulse_cnt_p1 <= pulse_cnt_p1 - PLS_ONE;
      end
    end

    assign btn_level[ch] = level_p1;
    assign btn_rise[ch]  = rise_p1;
    assign btn_fall[ch]  = fall_p1;
    assign btn_pulse[ch] = (pulse_cnt_p1 != '0);
  end

endmodule

// File: tb/tb_button_conditioner.sv
module tb_button_conditioner;

  logic clk = 1'b0;
  logic rst;
  logic [1:0] in_a;
  logic [1:0] in_m;
  logic [1:0] in_r;

  logic [1:0] lvl0, pls0, rse0, fal0;
  logic [1:0] lvl1, pls1, rse1, fal1;
  logic [1:0] lvl2, pls2, rse2, fal2;
  logic [1:0] lvl3, pls3, rse3, fal3;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // Rising-edge build.
  button_conditioner #(
    .CHANNELS(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .PULSE_LEN(3),
    .EDGE_MODE(0), .REPEAT_DELAY(1000), .REPEAT_PERIOD(1000)
  ) dut0 (
    .clk(clk), .rst(rst), .btn_in(in_a),
    .btn_level(lvl0), .btn_pulse(pls0), .btn_rise(rse0), .btn_fall(fal0)
  );

  // Falling-edge build.
  button_conditioner #(
    .CHANNELS(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .PULSE_LEN(3),
    .EDGE_MODE(1), .REPEAT_DELAY(1000), .REPEAT_PERIOD(1000)
  ) dut1 (
    .clk(clk), .rst(rst), .btn_in(in_m),
    .btn_level(lvl1), .btn_pulse(pls1), .btn_rise(rse1), .btn_fall(fal1)
  );

  // Both-edges build.
  button_conditioner #(
    .CHANNELS(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .PULSE_LEN(3),
    .EDGE_MODE(2), .REPEAT_DELAY(1000), .REPEAT_PERIOD(1000)
  ) dut2 (
    .clk(clk), .rst(rst), .btn_in(in_m),
    .btn_level(lvl2), .btn_pulse(pls2), .btn_rise(rse2), .btn_fall(fal2)
  );

  // Both-edges build with fast debounce and a long pulse, for retriggering.
  button_conditioner #(
    .CHANNELS(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(1), .PULSE_LEN(8),
    .EDGE_MODE(2), .REPEAT_DELAY(1000), .REPEAT_PERIOD(1000)
  ) dut3 (
    .clk(clk), .rst(rst), .btn_in(in_r),
    .btn_level(lvl3), .btn_pulse(pls3), .btn_rise(rse3), .btn_fall(fal3)
  );

`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
  logic [1:0] in_p;
  logic [1:0] lvl4, pls4, rse4, fal4;

  button_conditioner #(
    .CHANNELS(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .PULSE_LEN(3),
    .EDGE_MODE(0), .REPEAT_DELAY(10), .REPEAT_PERIOD(5)
  ) dut4 (
    .clk(clk), .rst(rst), .btn_in(in_p),
    .btn_level(lvl4), .btn_pulse(pls4), .btn_rise(rse4), .btn_fall(fal4)
  );
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst  = 1'b1;
    in_a = 2'b11;
    in_m = 2'b00;
    in_r = 2'b00;
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
    in_p = 2'b00;
`endif

    // Reset held with inputs high: every output stays low.
    step(); step(); step();
    chk("rst_level", 32'(lvl0), 32'd0);
    chk("rst_pulse", 32'(pls0), 32'd0);
    chk("rst_rise",  32'(rse0), 32'd0);
    chk("rst_fall",  32'(fal0), 32'd0);
    chk("rst_pulse3", 32'(pls3), 32'd0);

    // Release: level rises at cycle 6, pulse high for cycles 6..8.
    rst = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      step();
      chk($sformatf("rel_level_%0d", k), 32'(lvl0), (k >= 6) ? 32'd3 : 32'd0);
      chk($sformatf("rel_rise_%0d", k),  32'(rse0), (k == 6) ? 32'd3 : 32'd0);
      chk($sformatf("rel_pulse_%0d", k), 32'(pls0), (k >= 6 && k <= 8) ? 32'd3 : 32'd0);
      chk($sformatf("rel_fall_%0d", k),  32'(fal0), 32'd0);
    end

    // Release both channels: one fall strobe after 6 cycles, no pulse in mode 0.
    in_a = 2'b00;
    for (int k = 1; k <= 7; k++) begin
      step();
      chk($sformatf("off_level_%0d", k), 32'(lvl0), (k < 6) ? 32'd3 : 32'd0);
      chk($sformatf("off_fall_%0d", k),  32'(fal0), (k == 6) ? 32'd3 : 32'd0);
      chk($sformatf("off_pulse_%0d", k), 32'(pls0), 32'd0);
    end

    // Bounce on channel 0: 1,0,1 every 2 cycles, then held.
    in_a = 2'b01; step(); step();
    in_a = 2'b00; step(); step();
    in_a = 2'b01;
    for (int k = 1; k <= 9; k++) begin
      step();
      chk($sformatf("bnc_rise_%0d", k),  32'(rse0), (k == 6) ? 32'd1 : 32'd0);
      chk($sformatf("bnc_level_%0d", k), 32'(lvl0), (k >= 6) ? 32'd1 : 32'd0);
    end
    in_a = 2'b00;
    for (int k = 1; k <= 10; k++) step();
    chk("bnc_released", 32'(lvl0), 32'd0);

    // Glitch: 3 cycles high is one short of the debounce window.
    in_a = 2'b01;
    step(); step(); step();
    in_a = 2'b00;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk($sformatf("glitch_%0d", k), {24'd0, lvl0, pls0, rse0, fal0}, 32'd0);
    end

    // Modes: press 20 cycles then release.
    // Rise lands at cycle 6, fall at cycle 26.
    in_m = 2'b01;
    for (int k = 1; k <= 32; k++) begin
      step();
      if (k == 20) in_m = 2'b00;
      chk($sformatf("fallmode_pulse_%0d", k), 32'(pls1),
          (k >= 26 && k <= 28) ? 32'd1 : 32'd0);
      chk($sformatf("bothmode_pulse_%0d", k), 32'(pls2),
          ((k >= 6 && k <= 8) || (k >= 26 && k <= 28)) ? 32'd1 : 32'd0);
    end

    // Retrigger: rise at 3, release straight after, fall at 6 reloads -> 3..13.
    in_r = 2'b01;
    for (int k = 1; k <= 16; k++) begin
      step();
      if (k == 3) in_r = 2'b00;
      chk($sformatf("retrig_pulse_%0d", k), 32'(pls3), (k >= 3 && k <= 13) ? 32'd1 : 32'd0);
      chk($sformatf("retrig_rise_%0d", k),  32'(rse3), (k == 3) ? 32'd1 : 32'd0);
      chk($sformatf("retrig_fall_%0d", k),  32'(fal3), (k == 6) ? 32'd1 : 32'd0);
    end

    // Reset mid-debounce aborts the count; after release it restarts from scratch.
    in_a = 2'b11;
    step(); step(); step(); step();
    rst = 1'b1;
    step();
    chk("mid_rst_outputs", {24'd0, lvl0, pls0, rse0, fal0}, 32'd0);
    rst = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      step();
      chk($sformatf("mid_level_%0d", k), 32'(lvl0), (k >= 6) ? 32'd3 : 32'd0);
    end

    // Reset during an active pulse clears it the next cycle.
    chk("pulse_before_rst", 32'(pls0), 32'd3);
    rst = 1'b1;
    step();
    chk("pulse_abort", {24'd0, lvl0, pls0, rse0, fal0}, 32'd0);
    rst  = 1'b0;
    in_a = 2'b00;
    step();

`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
    // Auto-repeat: hold cycle 0 is the debounced rise (cycle 6).
    in_p = 2'b01;
    for (int k = 1; k <= 35; k++) begin
      int h;
      step();
      h = k - 6;
      chk($sformatf("rep_pulse_%0d", k), 32'(pls4),
          (h >= 0 && ((h % 5) <= 2) && (h < 3 || h >= 10)) ? 32'd1 : 32'd0);
      chk($sformatf("rep_rise_%0d", k), 32'(rse4), (k == 6) ? 32'd1 : 32'd0);
    end
    in_p = 2'b00;
    for (int k = 1; k <= 10; k++) step();

    // Reset at hold cycle 12 clears everything on the next cycle.
    in_p = 2'b01;
    for (int k = 1; k <= 18; k++) step();
    rst = 1'b1;
    step();
    chk("rep_rst", {24'd0, lvl4, pls4, rse4, fal4}, 32'd0);
    rst  = 1'b0;
    in_p = 2'b00;
    step();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
